// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_pkg
//  Description : Shared definitions for the Tomasulo core: functional-unit
//                indices, default ROB tag / data widths, function codes shared
//                by issue and the reservation stations, and an index-width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

  // Functional-unit indices, which are also CDB requester positions.
  localparam int FU_ADD = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LD  = 3;

  // Default widths (8-entry ROB, 16-bit datapath).
  localparam int DEF_TAG_W  = 3;
  localparam int DEF_DATA_W = 16;

  // Function codes.
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MUL  = 4'b0010;
  localparam logic [3:0] FN_DIV  = 4'b0011;
  localparam logic [3:0] FN_LD   = 4'b0100;
  localparam logic [3:0] FN_ST   = 4'b0101;
  localparam logic [3:0] FN_BEQ  = 4'b0110;
  localparam logic [3:0] FN_BNEQ = 4'b0111;

  // Width of an encoded index into n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Request and broadcast bundle of the CDB arbiter.
//                master : functional-unit side (drives requests and flush,
//                         observes grants and the broadcast)
//                slave  : arbiter side
//  Signals     : req_valid/req_tag/req_data/req_ready - per-unit handshake,
//                flush - squash, cdb_valid/cdb_tag/cdb_data/cdb_src -
//                registered broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
  import tomasulo_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int SRC_W = idx_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    flush;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Scans positions
//                ptr, ptr+1, ... (mod N) and selects the first set request.
//  Ports       : req   - request vector
//                ptr   - highest-priority position
//                grant - one-hot grant (all zero when no request)
//                idx   - encoded index of the grant
//                found - at least one request was set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import tomasulo_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] w_pos;

  // Walk from the lowest-priority offset up to the pointer itself so that the
  // last match written, i.e. the closest one to ptr, wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IDX_W'((int'(ptr) + k) % N);
      if (req[w_pos]) begin
        grant        = '0;
        grant[w_pos] = 1'b1;
        idx          = w_pos;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common Data Bus arbiter. Grants one finished functional unit
//                per cycle in round-robin order and broadcasts its ROB tag and
//                value on a registered CDB one cycle later. flush blocks the
//                grant in the current cycle and drops the broadcast next cycle.
//  Ports       : clk1  - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - cdb_arbiter_if.slave (requests, grants, flush, CDB)
//                perf_grant_cnt / perf_stall_cnt - per-unit 16-bit saturating
//                transfer and stall counters (only with CDB_PERF_EN)
//  Options     : `define CDB_PERF_EN to add the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk1,
  input  logic                rst_n,
`ifdef CDB_PERF_EN
  output logic [N_REQ*16-1:0] perf_grant_cnt,
  output logic [N_REQ*16-1:0] perf_stall_cnt,
`endif
  cdb_arbiter_if.slave        bus
);

  localparam int SRC_W = idx_w(N_REQ);

  logic [SRC_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [SRC_W-1:0]  r_cdb_src;

  logic [N_REQ-1:0]  w_pick_req;
  logic [N_REQ-1:0]  w_grant;
  logic [SRC_W-1:0]  w_idx;
  logic              w_xfer;
  logic [SRC_W-1:0]  w_next_ptr;

  // Flush masks every request, so no grant and no pointer movement.
  assign w_pick_req = bus.req_valid & {N_REQ{~bus.flush}};

  rr_pick #(
    .N     (N_REQ)
  ) u_pick (
    .req   (w_pick_req),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .found (w_xfer)
  );

  assign bus.req_ready = rst_n ? w_grant : '0;

  assign w_next_ptr = (w_idx == SRC_W'(N_REQ - 1)) ? '0 : w_idx + SRC_W'(1);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_xfer;
      // Without a transfer the payload holds its last broadcast.
      if (w_xfer) begin
        r_rr_ptr   <= w_next_ptr;
        r_cdb_tag  <= bus.req_tag[w_idx*TAG_W +: TAG_W];
        r_cdb_data <= bus.req_data[w_idx*DATA_W +: DATA_W];
        r_cdb_src  <= w_idx;
      end
    end
  end

  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_data  = r_cdb_data;
  assign bus.cdb_src   = r_cdb_src;

`ifdef CDB_PERF_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_perf
    logic [15:0] r_grant_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
        r_grant_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (bus.req_valid[i] && bus.req_ready[i] && (r_grant_cnt != 16'hFFFF))
          r_grant_cnt <= r_grant_cnt + 16'd1;
        // Flush cycles count as stalls since ready is forced low.
        if (bus.req_valid[i] && !bus.req_ready[i] && (r_stall_cnt != 16'hFFFF))
          r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end

    assign perf_grant_cnt[i*16 +: 16] = r_grant_cnt;
    assign perf_stall_cnt[i*16 +: 16] = r_stall_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. Stimulus drives directed
//                request vectors and pushes the expected next-cycle broadcast
//                into a queue; an independent monitor pops and compares on
//                every falling edge. Grants are compared in the stimulus task.
//  Options     : CDB_PERF_EN enables the performance-counter section.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  typedef struct {
    int          cyc;
    logic        v;
    logic        chk;
    logic [2:0]  tag;
    logic [15:0] data;
    logic [1:0]  src;
  } exp_t;

  logic clk1  = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  cdb_arbiter_if #(.N_REQ(4), .TAG_W(3), .DATA_W(16)) bus ();

`ifdef CDB_PERF_EN
  logic [63:0] perf_grant_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  cdb_arbiter #(
    .N_REQ  (4),
    .TAG_W  (3),
    .DATA_W (16)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
`ifdef CDB_PERF_EN
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  // Broadcast monitor.
  always @(negedge clk1) begin
    exp_t e;
    logic ok;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL cdb_missed: entry for cycle %0d not compared (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      ok = (bus.cdb_valid === e.v);
      if (e.chk)
        ok = ok && (bus.cdb_tag === e.tag) && (bus.cdb_data === e.data) && (bus.cdb_src === e.src);
      if (!ok) begin
        errors++;
        $display("FAIL cdb cycle %0d: got v=%b tag=%0d data=%h src=%0d, expected v=%b tag=%0d data=%h src=%0d (payload checked=%b)",
                 cyc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, e.v, e.tag, e.data, e.src, e.chk);
      end
    end
  end

  // One arbitration cycle: drive, queue the next-cycle broadcast, check grant.
  task automatic step(input logic [3:0] v, input logic [11:0] tags, input logic [63:0] datas,
                      input logic fl, input logic [3:0] exp_rdy,
                      input logic ev, input logic ech, input logic [2:0] et,
                      input logic [15:0] ed, input logic [1:0] es);
    exp_t e;
    @(posedge clk1);
    #1;
    bus.req_valid = v;
    bus.req_tag   = tags;
    bus.req_data  = datas;
    bus.flush     = fl;
    e.cyc = cyc + 1; e.v = ev; e.chk = ech; e.tag = et; e.data = ed; e.src = es;
    q.push_back(e);
    @(negedge clk1);
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL req_ready cycle %0d: got %b expected %b", cyc, bus.req_ready, exp_rdy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.flush     = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_cdb_valid: got %b expected 0", bus.cdb_valid);
    end
    repeat (2) @(posedge clk1);
    #1;
    bus.req_valid = 4'b0000;
    rst_n         = 1'b1;
  endtask

  localparam logic [11:0] c_rot_tags = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [63:0] c_rot_data = {16'h1004, 16'h1003, 16'h1002, 16'h1001};

  initial begin
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk1);

    // Reset, then first grant from index 0.
    do_reset();
    step(4'b1111, {3'd4, 3'd3, 3'd2, 3'd5}, {16'h1004, 16'h1003, 16'h1002, 16'h00AA}, 1'b0,
         4'b0001, 1'b1, 1'b1, 3'd5, 16'h00AA, 2'd0);

    // Reset mid-operation: pointer back to 0.
    do_reset();

    // Rotation with wrap.
    step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'b0001, 1'b1, 1'b1, 3'd1, 16'h1001, 2'd0);
    step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'b0010, 1'b1, 1'b1, 3'd2, 16'h1002, 2'd1);
    step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'b0100, 1'b1, 1'b1, 3'd3, 16'h1003, 2'd2);
    step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'b1000, 1'b1, 1'b1, 3'd4, 16'h1004, 2'd3);
    step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'b0001, 1'b1, 1'b1, 3'd1, 16'h1001, 2'd0);

    // Single persistent requester, back-to-back broadcasts.
    step(4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, {16'h0, 16'h0010, 16'h0, 16'h0}, 1'b0,
         4'b0100, 1'b1, 1'b1, 3'd7, 16'h0010, 2'd2);
    step(4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, {16'h0, 16'h0011, 16'h0, 16'h0}, 1'b0,
         4'b0100, 1'b1, 1'b1, 3'd7, 16'h0011, 2'd2);
    step(4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, {16'h0, 16'h0012, 16'h0, 16'h0}, 1'b0,
         4'b0100, 1'b1, 1'b1, 3'd7, 16'h0012, 2'd2);
    // Unit 0 raised: pointer is at 3, so 0 comes before 2.
    step(4'b0101, {3'd0, 3'd7, 3'd0, 3'd2}, {16'h0, 16'h0013, 16'h0, 16'h0020}, 1'b0,
         4'b0001, 1'b1, 1'b1, 3'd2, 16'h0020, 2'd0);

    // Flush with units 1 and 3 pending; unit 0 broadcast still visible now.
    step(4'b1010, {3'd3, 3'd0, 3'd1, 3'd0}, {16'h0033, 16'h0, 16'h0031, 16'h0}, 1'b1,
         4'b0000, 1'b0, 1'b0, 3'd0, 16'h0, 2'd0);
    step(4'b1010, {3'd3, 3'd0, 3'd1, 3'd0}, {16'h0033, 16'h0, 16'h0031, 16'h0}, 1'b0,
         4'b0010, 1'b1, 1'b1, 3'd1, 16'h0031, 2'd1);
    step(4'b1000, {3'd3, 3'd0, 3'd1, 3'd0}, {16'h0033, 16'h0, 16'h0031, 16'h0}, 1'b0,
         4'b1000, 1'b1, 1'b1, 3'd3, 16'h0033, 2'd3);

    // Idle hold after a tag-6 transfer.
    step(4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, {16'h0, 16'h0, 16'h0066, 16'h0}, 1'b0,
         4'b0010, 1'b1, 1'b1, 3'd6, 16'h0066, 2'd1);
    step(4'b0000, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd6, 16'h0066, 2'd1);
    step(4'b0000, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd6, 16'h0066, 2'd1);

`ifdef CDB_PERF_EN
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, c_rot_tags, c_rot_data, 1'b0, 4'(1 << (k % 4)),
           1'b1, 1'b1, 3'((k % 4) + 1), 16'h1001 + 16'(k % 4), 2'(k % 4));
    end
    step(4'b0000, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd4, 16'h1004, 2'd3);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (perf_grant_cnt[u*16 +: 16] !== 16'd2 || perf_stall_cnt[u*16 +: 16] !== 16'd6) begin
        errors++;
        $display("FAIL perf_cnt unit %0d: got grant=%0d stall=%0d expected grant=2 stall=6",
                 u, perf_grant_cnt[u*16 +: 16], perf_stall_cnt[u*16 +: 16]);
      end
    end
    force dut.g_perf[0].r_grant_cnt = 16'hFFFF;
    #1;
    release dut.g_perf[0].r_grant_cnt;
    step(4'b0001, c_rot_tags, c_rot_data, 1'b0, 4'b0001, 1'b1, 1'b1, 3'd1, 16'h1001, 2'd0);
    step(4'b0000, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 16'h1001, 2'd0);
    checks++;
    if (perf_grant_cnt[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_saturate: got %h expected ffff", perf_grant_cnt[15:0]);
    end
`endif

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk1);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected broadcasts never compared, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common Data Bus (CDB) arbiter for the Tomasulo core.
- Functional units (add/sub, mul, div, load) each hold a finished result (ROB tag plus value). The block grants exactly one of them per cycle, round-robin.
- The winner is broadcast on a registered CDB, which feeds the reservation stations, the register bank ROB-tag match and ROB writeback.
- A flush input, driven by branch mispredict, squashes in-flight broadcasts.

Parameters:
- N_REQ, 4, number of requesting functional units (index 0 = add, 1 = mul, 2 = div, 3 = load).
- TAG_W, 3, ROB tag width (8-entry ROB).
- DATA_W, 16, result data width.

Ports:
- clk1  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  unit i holds a completed result.
- req_tag  in  N_REQ*TAG_W  ROB tag of unit i, packed; slice i = [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  result of unit i, packed likewise.
- req_ready  out  N_REQ  one-hot grant; unit i's result is accepted this cycle.
- flush  in  1  squash: no grant this cycle, and the CDB drops next cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(N_REQ)  index of the unit that produced the broadcast.

Behaviour:
- Reset values (async, rst_n=0): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
- req_ready is combinational; it is 0 whenever rst_n=0 or flush=1.
- Handshake:
  - valid/ready. A transfer occurs when req_valid[i] & req_ready[i].
  - Units hold valid, tag and data stable until the transfer.
  - Units must not drop valid before the transfer, except on flush.
- Grant rule:
  - Scan indices rr_ptr, rr_ptr+1, … mod N_REQ.
  - The first index with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - If no request is valid, all ready bits are 0.
- Pointer update: on a transfer from unit g, rr_ptr <= (g+1) mod N_REQ. With no transfer, rr_ptr holds. Wrap from N_REQ-1 goes to 0.
- Output register, 1-cycle latency:
  - On a transfer in cycle t, cycle t+1 shows cdb_valid=1, cdb_tag/cdb_data equal to unit g's tag/data, and cdb_src=g.
  - With no transfer, cdb_valid <= 0 and tag/data/src hold their last values.
- Back-to-back: a single persistent requester is granted every cycle. Consecutive grants to the same unit produce consecutive broadcasts.
- Fairness: with all N_REQ units continuously valid, grants rotate strictly. Maximum wait is N_REQ-1 cycles.
- flush=1 in cycle t:
  - req_ready=0 in cycle t and rr_ptr holds.
  - cdb_valid=0 in cycle t+1, regardless of requests.
  - A broadcast already showing in cycle t stays visible in cycle t (the flush does not retract it combinationally).
- Reset mid-operation clears state immediately. Any pending request is re-arbitrated from index 0 after reset deasserts.
- Width rule: tags and data pass through unmodified, with no arithmetic.

Optional Feature:
- Macro: CDB_PERF_EN.
- Defined:
  - Adds ports perf_grant_cnt (out, N_REQ*16), per-unit transfer counts.
  - Adds perf_stall_cnt (out, N_REQ*16), per-unit cycles with req_valid=1 & req_ready=0, flush cycles included.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Decomposition:
- Shared package tomasulo_pkg holds:
  - the FU index constants (FU_ADD=0, FU_MUL=1, FU_DIV=2, FU_LD=3);
  - TAG_W and DATA_W defaults;
  - the function code localparams (add=4'b0000 … bneq=4'b0111), shared with issue and the reservation stations.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are req vector and ptr; outputs are one-hot grant and encoded index. It is reusable for reservation-station issue select.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 → req_ready=0 and cdb_valid=0. After release, the first grant goes to unit 0 (tag 3'd5, data 16'h00AA), and the next cycle shows cdb_valid=1, cdb_tag=5, cdb_data=16'h00AA, cdb_src=0.
- Rotation: all four units continuously valid with tags 1, 2, 3, 4 → grants 0, 1, 2, 3, 0 on consecutive cycles, CDB tags 1, 2, 3, 4, 1 one cycle later, and rr_ptr wraps.
- Single requester: only unit 2 valid for 3 transfers (data 16'h0010, 16'h0011, 16'h0012) → three consecutive cdb_valid cycles with cdb_src=2 and the matching data. Unit 0 raised afterwards is granted next.
- Flush: units 1 and 3 valid, flush=1 for one cycle → no ready and cdb_valid=0 in the following cycle. The next grant goes to unit 1, showing the pointer was unchanged.
- Idle hold: a transfer of tag 6, then no requests → cdb_valid drops to 0 while cdb_tag stays 6.
- CDB_PERF_EN: 4 continuous requesters for 8 cycles → each perf_grant_cnt = 2 and each perf_stall_cnt = 6. Preloading a counter to 16'hFFFF via forced stimulus → it stays saturated.
